// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, pointer type and level-compare helper for the level-flagged FIFOs.
package fifo_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_AW    = 9;
    typedef logic [FIFO_AW:0] fifo_ptr_t;
    function automatic logic lvl_ge(input int unsigned a, input int unsigned b);
        return a >= b;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2^AW x WIDTH storage; read port is combinational with FIFO_FWFT_EN, registered otherwise.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int AW    = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [2**AW];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
`ifdef FIFO_FWFT_EN
    logic w_unused;
    assign w_unused = i_re ^ i_rst_n;
    assign o_rdata  = r_mem[i_raddr];
`else
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= '0;
        else if (i_re) r_q <= r_mem[i_raddr];
    end
    assign o_rdata = r_q;
`endif
endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: synchronous FIFO with occupancy count, level thresholds, flush and sticky OVF/UDF.
// Define FIFO_FWFT_EN for first-word-fall-through; default is registered read with a valid strobe.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int AW    = FIFO_AW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [AW:0]      i_af_lvl,
    input  logic [AW:0]      i_ae_lvl,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qv,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_afull,
    output logic             o_aempty,
    output logic [AW:0]      o_cnt,
    output logic             o_ovf,
    output logic             o_udf
);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH = ptr_t'(1) << AW;
    ptr_t r_wp, r_rp, w_cnt;
    logic r_run, r_ovf, r_udf, w_wr_ok, w_rd_ok;
    assign w_cnt    = r_wp - r_rp;
    assign o_cnt    = w_cnt;
    assign o_full   = w_cnt == DEPTH;
    assign o_empty  = w_cnt == '0;
    assign o_afull  = lvl_ge(32'(w_cnt), 32'(i_af_lvl));
    assign o_aempty = lvl_ge(32'(i_ae_lvl), 32'(w_cnt));
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;
    // r_run blocks any access on the edge that releases reset
    assign w_wr_ok  = r_run & i_wr & ~o_full & ~i_clr;
    assign w_rd_ok  = r_run & i_rd & ~o_empty & ~i_clr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (i_clr) begin
            r_run <= 1'b1;
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_wp  <= r_wp + ptr_t'(w_wr_ok);
            r_rp  <= r_rp + ptr_t'(w_rd_ok);
            r_ovf <= r_ovf | (r_run & i_wr & o_full);
            r_udf <= r_udf | (r_run & i_rd & o_empty);
        end
    end
`ifdef FIFO_FWFT_EN
    assign o_qv = ~o_empty;
`else
    logic r_qv;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_qv <= 1'b0;
        else r_qv <= w_rd_ok;
    end
    assign o_qv = r_qv;
`endif
    fifo_mem #(.WIDTH(WIDTH), .AW(AW)) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_wr_ok),
        .i_waddr (r_wp[AW-1:0]),
        .i_wdata (i_d),
        .i_re    (w_rd_ok),
        .i_raddr (r_rp[AW-1:0]),
        .o_rdata (o_q)
    );
endmodule

// File: doc/fifo_lvl.md
# fifo_lvl

Parametrised synchronous FIFO that replaces the fixed 8×512 buffer in the dataflow path between the engine's operand loaders and the MAC array. It adds level thresholds, an occupancy count, a synchronous flush, sticky overflow/underflow error flags, and a registered read port with a valid strobe. First-word-fall-through can be compiled in.

## Interface
- WIDTH, 8: data bus width in bits.
- AW, 9: address width; depth is 2^AW words.
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- CLR  in  1  synchronous flush; empties the FIFO and clears OVF/UDF.
- D  in  WIDTH  write data.
- WR  in  1  write request.
- RD  in  1  read request, or read acknowledge in FWFT mode.
- AF_LVL  in  AW+1  almost-full threshold; quasi-static.
- AE_LVL  in  AW+1  almost-empty threshold; quasi-static.
- Q  out  WIDTH  read data.
- QV  out  1  Q valid.
- FULL  out  1  CNT == 2^AW.
- EMPTY  out  1  CNT == 0.
- AFULL  out  1  CNT >= AF_LVL.
- AEMPTY  out  1  CNT <= AE_LVL.
- CNT  out  AW+1  occupancy, 0..2^AW.
- OVF  out  1  sticky: a write was attempted while FULL.
- UDF  out  1  sticky: a read was attempted while EMPTY.

## Operation
- Write and read pointers are AW+1 bits. Only the low AW bits address storage, and the pointers wrap modulo 2^(AW+1). CNT = WP − RP, computed modulo 2^(AW+1).
- A write is accepted when WR & ~FULL: D is stored at WP[AW-1:0] and WP increments.
- WR & FULL drops the data and sets OVF. This holds even if RD is accepted in the same cycle, because FULL is sampled pre-edge.
- A read is accepted when RD & ~EMPTY, and RP increments.
- RD & EMPTY sets UDF. This holds even if WR is accepted in the same cycle.
- When a read and a write are both accepted in one cycle, CNT is unchanged.
- All flags and CNT are combinational from the registered pointers, so they reflect an accepted operation one cycle after its edge.
- CLR has priority over WR and RD in the same cycle. It zeroes WP, RP, QV, OVF and UDF. Storage contents are not cleared. Q holds its value.
- Threshold edge cases:
  - AF_LVL = 0 forces AFULL = 1.
  - AE_LVL >= 2^AW forces AEMPTY = 1.
  - A threshold change takes effect combinationally.
- Reset (nRST low, asynchronous) sets WP = RP = 0, Q = 0, QV = 0, OVF = UDF = 0. Resulting outputs: EMPTY = 1, FULL = 0, CNT = 0, AEMPTY = 1, AFULL = (AF_LVL == 0).
- Reset asserted mid-transfer discards all contents. No write or read is accepted on the edge where nRST is released.

## Timing
- Standard mode, read latency 1:
  - An accepted read at edge N presents the head word on Q with QV = 1 after edge N. QV is high for one cycle per accepted read.
  - Otherwise QV = 0 and Q holds its last value.
- Back-to-back reads produce a new Q/QV every cycle.
- Write-to-readable latency is 1: EMPTY deasserts after the write edge, and RD may be issued in that cycle.
- Full throughput: one write and one read per cycle at any occupancy except the FULL-write and EMPTY-read cases above.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through):
  - Q = storage[RP] and QV = ~EMPTY, both combinational.
  - RD acknowledges the presented word. The next word, if any, appears after that edge.
  - Write-to-QV latency is 1 cycle. Q is don't-care while QV = 0.
  - The UDF rule is unchanged.
- FIFO_FWFT_EN undefined: standard registered-read mode as described under Timing.

## Structure
- Package fifo_pkg holds:
  - default WIDTH/AW constants;
  - the pointer typedef, sized by AW+1;
  - the count-compare helper function shared with the other level-flagged buffers in the engine.
- Sub-module fifo_mem holds the 2^AW × WIDTH storage:
  - one synchronous write port;
  - one read port, asynchronous in FWFT mode and registered in standard mode.
- All pointer, flag and sticky-bit logic stays in fifo_lvl.

## Test plan
- Reset, then fill, then drain (WIDTH=8, AW=2, AF_LVL=3, AE_LVL=1):
  - Stimulus: write 0x11, 0x22, 0x33, 0x44, then read four times.
  - Fill: CNT steps 1..4, AFULL first seen at CNT=3, FULL at CNT=4, AEMPTY clears at CNT=2.
  - Drain: Q/QV yields 0x11..0x44 in order, one cycle after each RD, and EMPTY returns.
- Overflow/underflow:
  - Stimulus: fifth write 0x55 while FULL, then drain, then RD while EMPTY.
  - Required: 0x55 is never read, OVF = 1, UDF = 1, CNT never exceeds 4.
  - Then pulse CLR: OVF = UDF = 0, CNT = 0.
- Simultaneous access at CNT=2 with WR = RD = 1 for 10 cycles:
  - CNT stays 2 throughout.
  - Q sequence is continuous, with no loss or duplication across pointer wrap (RP passes 7→0).
- Mid-operation reset:
  - Stimulus: nRST pulsed low between edges at CNT=3.
  - Required: immediately EMPTY = 1, CNT = 0, QV = 0, Q = 0. A write on the release edge is ignored.
- With FIFO_FWFT_EN:
  - Stimulus: write 0xA5 into an empty FIFO.
  - Required: QV = 1 with Q = 0xA5 one cycle later, before any RD.
  - Then RD: QV = 0 next cycle, EMPTY = 1.
